// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants and helpers for the sync_fifo slice.
//   clog2()  - ceiling log2, usable in constant expressions
//   ptr_w()  - pointer/count width for a given depth (one extra wrap bit)
//   DEF_*    - widths derived from the default depth of 8
package sync_fifo_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Pointers carry one bit beyond the address so full and empty differ.
  function automatic int ptr_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  localparam int DEF_DEPTH  = 8;
  localparam int DEF_ADDR_W = clog2(DEF_DEPTH);
  localparam int DEF_PTR_W  = ptr_w(DEF_DEPTH);

endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: handshake/data bundle between a FIFO user and sync_fifo.
//   master : drives wr_en, din, rd_en; observes data and status
//   slave  : the FIFO itself (drives dout, flags, data_count, error pulses)
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
);
  localparam int CNT_W = ptr_w(FIFO_DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_W-1:0]      data_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, din, rd_en,
    input  dout, full, empty, almost_full, almost_empty, data_count,
           overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en,
    output dout, full, empty, almost_full, almost_empty, data_count,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: storage array for sync_fifo.
//   clk   - write clock
//   we    - write enable, waddr/wdata written on rising edge
//   raddr - read address, rdata is a combinational read of the array
// Contents are intentionally not reset.
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, threshold flags and
// overflow/underflow pulses.
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - sync_fifo_if.slave: wr_en/din/rd_en in; dout, full, empty,
//          almost_full, almost_empty, data_count, overflow, underflow out
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through dout
// (head word visible whenever non-empty); default is a registered dout
// that updates one cycle after an accepted read.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int ALMOST_WR  = 2,
  parameter int ALMOST_RD  = 1
) (
  input  logic        clk,
  input  logic        rst,
  sync_fifo_if.slave  bus
);
  localparam int ADDR_W = clog2(FIFO_DEPTH);
  localparam int PTR_W  = ptr_w(FIFO_DEPTH);

  logic [PTR_W-1:0]      wr_ptr, rd_ptr, count;
  logic                  full, empty, wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] rd_data;

  // Flags come only from registered pointers/count, never from wr_en/rd_en.
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // Acceptance uses the current flags, so at full a concurrent read does
  // not free space for the same-cycle write (and vice versa at empty).
  assign wr_ok = bus.wr_en & ~full;
  assign rd_ok = bus.rd_en & ~empty;

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (bus.din),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + PTR_W'(1);
        2'b01:   count <= count - PTR_W'(1);
        default: count <= count;
      endcase
      bus.overflow  <= bus.wr_en & full;
      bus.underflow <= bus.rd_en & empty;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word falls through; zero while empty so reset shows dout=0.
  assign bus.dout = empty ? '0 : rd_data;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        bus.dout <= '0;
    else if (rd_ok) bus.dout <= rd_data;
  end
`endif

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.data_count   = count;
  assign bus.almost_full  = (count >= PTR_W'(FIFO_DEPTH - ALMOST_WR));
  assign bus.almost_empty = (count <= PTR_W'(ALMOST_RD));
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the data word width in bits.
REQ-002 Parameter FIFO_DEPTH, default 8, SHALL set the number of storage words; power of two, at least 2.
REQ-003 Parameter ALMOST_WR, default 2, SHALL set the almost_full margin in words; range 1 to FIFO_DEPTH-1.
REQ-004 Parameter ALMOST_RD, default 1, SHALL set the almost_empty threshold in words; range 1 to FIFO_DEPTH-1.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-006 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 rst  in  1  SHALL be the asynchronous active-high reset.
REQ-008 wr_en  in  1  SHALL be the write request.
REQ-009 din  in  DATA_WIDTH  SHALL be the write data.
REQ-010 rd_en  in  1  SHALL be the read request.
REQ-011 dout  out  DATA_WIDTH  SHALL be the read data.
REQ-012 full, empty  out  1 each  SHALL be the occupancy equal to FIFO_DEPTH / occupancy equal to 0 flags.
REQ-013 almost_full, almost_empty  out  1 each  SHALL be the threshold flags.
REQ-014 data_count  out  clog2(FIFO_DEPTH)+1  SHALL give the current occupancy, range 0..FIFO_DEPTH inclusive.
REQ-015 overflow, underflow  out  1 each  SHALL be one-cycle error pulses.

Function
REQ-016 A write SHALL be accepted only when wr_en=1 and full=0; the data is stored at the write pointer, and the write pointer then increments.
REQ-017 A read SHALL be accepted only when rd_en=1 and empty=0; the read pointer then increments.
REQ-018 Pointers SHALL be clog2(FIFO_DEPTH)+1 bits wide, and they SHALL wrap naturally.
REQ-019 The full condition SHALL be: pointer MSBs differ and the low bits are equal.
REQ-020 The empty condition SHALL be: both pointers are equal.
REQ-021 data_count SHALL be updated in the cycle after an accepted operation, as follows.
- +1 for a write only.
- -1 for a read only.
- Unchanged for simultaneous accepted write and read.
REQ-022 All flags SHALL derive from registered state only, with no combinational path from wr_en or rd_en.
REQ-023 almost_full SHALL be 1 when data_count >= FIFO_DEPTH-ALMOST_WR.
REQ-024 almost_empty SHALL be 1 when data_count <= ALMOST_RD.
REQ-025 When full with wr_en=1 and rd_en=1, the read SHALL be accepted, the write refused, and overflow pulsed.
REQ-026 When empty with wr_en=1 and rd_en=1, the write SHALL be accepted, the read refused, and underflow pulsed.
REQ-027 overflow SHALL pulse for exactly one cycle, in the cycle after each refused write.
REQ-028 underflow SHALL pulse for exactly one cycle, in the cycle after each refused read.
REQ-029 In standard mode, dout SHALL be registered: it presents the popped word one cycle after an accepted read, and otherwise holds its value.
REQ-030 Refused operations SHALL alter neither the memory contents, the pointers, nor dout.

Reset
REQ-031 While rst=1, the following SHALL hold, immediately and independent of clk.
- Pointers and data_count are 0.
- empty=1, almost_empty=1.
- full=0, almost_full=0.
- overflow=0, underflow=0.
- dout=0.
REQ-032 Reset mid-operation SHALL discard all stored data; storage contents are not cleared.
REQ-033 The first operation after reset SHALL be accepted on the first rising clk edge at which rst=0.

Configuration
REQ-034 Macro SYNC_FIFO_FWFT_EN, when defined, SHALL compile in first-word-fall-through mode.
- dout equals the head word whenever empty=0.
- rd_en acknowledges and pops that word.
- The next word appears in the following cycle.
REQ-035 Without SYNC_FIFO_FWFT_EN, the standard mode of REQ-029 SHALL apply.
REQ-036 The macro SHALL NOT change the port list or the flag behaviour.

Structure
REQ-037 Package sync_fifo_pkg SHALL hold the clog2 function and the pointer/count width constants derived from FIFO_DEPTH.
REQ-038 Storage SHALL be the sub-module sync_fifo_ram.
- Register array with one synchronous write port and one read port.
- Not reset.

Verification (DATA_WIDTH=8, FIFO_DEPTH=8, ALMOST_WR=2, ALMOST_RD=1)
REQ-039 Fill test: write 17,20,1..6 -> after the 6th write almost_full=1; after the 8th write full=1 and data_count=8. A 9th write (value 99) -> overflow pulses 1 cycle and data_count stays 8.
REQ-040 Drain test: 8 reads then a 9th read -> dout sequence 17,20,1..6. After the 7th read almost_empty=1; after the 8th read empty=1; the 9th read pulses underflow and dout holds 6.
REQ-041 Simultaneous at full: wr_en=rd_en=1 with value 50 -> dout=17, write refused, overflow=1, data_count=7.
REQ-042 Simultaneous at empty: wr_en=rd_en=1 with value 33 -> underflow=1, data_count=1, and a later read returns 33.
REQ-043 Wrap and reset test: run 20 write/read pairs with values 0..19 -> in-order output with data_count never above 1. Then write 3 words and assert rst mid-cycle -> empty=1 and data_count=0 immediately.
REQ-044 FWFT build: write 42 to an empty FIFO -> next cycle empty=0 and dout=42 with no rd_en. A single rd_en then pops the word and empty=1.
